// File: rtl/axicb_mst_switch.sv
// Master-side crossbar switch: decodes AW/AR to a slave port, steers W beats in AW order,
// arbitrates B/R back to the master, and answers unmapped addresses with DECERR.
module axicb_mst_switch #(
    parameter int unsigned AXI_ADDR_W = 16,
    parameter int unsigned AXI_ID_W   = 8,
    parameter int unsigned AXI_DATA_W = 8,
    parameter int unsigned SLV_NB     = 4,
    parameter int unsigned OSTDREQ_NB = 4,
    parameter logic [AXI_ADDR_W-1:0] SLV0_START_ADDR = 'h0000,
    parameter logic [AXI_ADDR_W-1:0] SLV0_END_ADDR   = 'h0FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV1_START_ADDR = 'h1000,
    parameter logic [AXI_ADDR_W-1:0] SLV1_END_ADDR   = 'h1FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV2_START_ADDR = 'h2000,
    parameter logic [AXI_ADDR_W-1:0] SLV2_END_ADDR   = 'h2FFF,
    parameter logic [AXI_ADDR_W-1:0] SLV3_START_ADDR = 'h3000,
    parameter logic [AXI_ADDR_W-1:0] SLV3_END_ADDR   = 'h3FFF,
    parameter int unsigned AWCH_W = 32,
    parameter int unsigned WCH_W  = 8,
    parameter int unsigned ARCH_W = 40,
    parameter int unsigned BCH_W  = 2 + AXI_ID_W,
    parameter int unsigned RCH_W  = 2 + AXI_ID_W + AXI_DATA_W
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       srst,
    input  logic                       i_awvalid,
    output logic                       i_awready,
    input  logic [AWCH_W-1:0]          i_awch,
    input  logic                       i_wvalid,
    output logic                       i_wready,
    input  logic                       i_wlast,
    input  logic [WCH_W-1:0]           i_wch,
    output logic                       i_bvalid,
    input  logic                       i_bready,
    output logic [BCH_W-1:0]           i_bch,
    input  logic                       i_arvalid,
    output logic                       i_arready,
    input  logic [ARCH_W-1:0]          i_arch,
    output logic                       i_rvalid,
    input  logic                       i_rready,
    output logic                       i_rlast,
    output logic [RCH_W-1:0]           i_rch,
    output logic [SLV_NB-1:0]          o_awvalid,
    input  logic [SLV_NB-1:0]          o_awready,
    output logic [SLV_NB*AWCH_W-1:0]   o_awch,
    output logic [SLV_NB-1:0]          o_wvalid,
    input  logic [SLV_NB-1:0]          o_wready,
    output logic [SLV_NB-1:0]          o_wlast,
    output logic [SLV_NB*WCH_W-1:0]    o_wch,
    input  logic [SLV_NB-1:0]          o_bvalid,
    output logic [SLV_NB-1:0]          o_bready,
    input  logic [SLV_NB*BCH_W-1:0]    o_bch,
    output logic [SLV_NB-1:0]          o_arvalid,
    input  logic [SLV_NB-1:0]          o_arready,
    output logic [SLV_NB*ARCH_W-1:0]   o_arch,
    input  logic [SLV_NB-1:0]          o_rvalid,
    output logic [SLV_NB-1:0]          o_rready,
    input  logic [SLV_NB-1:0]          o_rlast,
    input  logic [SLV_NB*RCH_W-1:0]    o_rch
);

    localparam int unsigned TGT_W = $clog2(SLV_NB + 1);
    localparam int unsigned PTR_W = $clog2(OSTDREQ_NB);
    localparam logic [TGT_W-1:0] ERR = TGT_W'(SLV_NB);

    typedef enum logic [1:0] {WIdle, WData, WResp} werr_e;
    typedef enum logic [0:0] {RIdle, RBurst} rerr_e;

    function automatic logic in_window(input logic [AXI_ADDR_W-1:0] addr, input int n);
        logic hit;
        case (n)
            0:       hit = addr >= SLV0_START_ADDR && addr <= SLV0_END_ADDR;
            1:       hit = addr >= SLV1_START_ADDR && addr <= SLV1_END_ADDR;
            2:       hit = addr >= SLV2_START_ADDR && addr <= SLV2_END_ADDR;
            default: hit = addr >= SLV3_START_ADDR && addr <= SLV3_END_ADDR;
        endcase
        return hit;
    endfunction

    // Scanning downwards lets the lowest matching window win on overlap.
    function automatic logic [TGT_W-1:0] decode(input logic [AXI_ADDR_W-1:0] addr);
        logic [TGT_W-1:0] t;
        t = ERR;
        for (int n = int'(SLV_NB) - 1; n >= 0; n--) begin
            if (in_window(addr, n)) t = TGT_W'(n);
        end
        return t;
    endfunction

    function automatic logic [TGT_W-1:0] rr_pick(input logic [SLV_NB:0] req,
                                                 input logic [TGT_W-1:0] ptr);
        logic [TGT_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < int'(SLV_NB) + 1; i++) begin
            idx = int'(ptr) + i;
            if (idx > int'(SLV_NB)) idx = idx - int'(SLV_NB) - 1;
            if (!found && req[idx]) begin
                sel   = TGT_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [TGT_W-1:0] rr_next(input logic [TGT_W-1:0] g);
        return (g == ERR) ? '0 : g + TGT_W'(1);
    endfunction

    logic [TGT_W-1:0] fifo_q [OSTDREQ_NB];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             fifo_full, fifo_empty, push, pop;
    logic [TGT_W-1:0] aw_tgt, ar_tgt, head;

    werr_e               werr_q, werr_d;
    rerr_e               rerr_q, rerr_d;
    logic                werr_idle, err_bvalid, rerr_idle, err_rvalid;
    logic [AXI_ID_W-1:0] werr_id_q, rerr_id_q;
    logic [7:0]          rerr_cnt_q;

    logic [TGT_W-1:0] b_ptr_q, b_gnt_q, b_gnt;
    logic             b_lock_q;
    logic [TGT_W-1:0] r_ptr_q, r_gnt_q, r_gnt;
    logic             r_lock_q;
    logic [SLV_NB:0]  b_req, r_req;
    logic             b_hs, r_hs, r_done, err_ar_hs, err_r_hs, err_pop, err_push;

    assign fifo_full  = cnt_q == (PTR_W + 1)'(OSTDREQ_NB);
    assign fifo_empty = cnt_q == '0;
    assign head       = fifo_q[rd_ptr_q];
    assign o_awch     = {SLV_NB{i_awch}};
    assign o_wch      = {SLV_NB{i_wch}};
    assign o_wlast    = {SLV_NB{i_wlast}};
    assign o_arch     = {SLV_NB{i_arch}};

    always_comb begin
        aw_tgt    = decode(i_awch[AXI_ADDR_W-1:0]);
        o_awvalid = '0;
        i_awready = !fifo_full && werr_idle;
        for (int n = 0; n < int'(SLV_NB); n++) begin
            if (aw_tgt == TGT_W'(n)) begin
                o_awvalid[n] = i_awvalid && !fifo_full;
                i_awready    = !fifo_full && o_awready[n];
            end
        end
        push     = i_awvalid && i_awready;
        err_push = push && aw_tgt == ERR;

        // The internal sink behind an ERR head accepts every beat.
        o_wvalid = '0;
        i_wready = !fifo_empty && head == ERR;
        for (int n = 0; n < int'(SLV_NB); n++) begin
            if (!fifo_empty && head == TGT_W'(n)) begin
                o_wvalid[n] = i_wvalid;
                i_wready    = o_wready[n];
            end
        end
        pop     = i_wvalid && i_wready && i_wlast;
        err_pop = pop && head == ERR;
    end

    always_comb begin
        ar_tgt    = decode(i_arch[AXI_ADDR_W-1:0]);
        o_arvalid = '0;
        i_arready = rerr_idle;
        for (int n = 0; n < int'(SLV_NB); n++) begin
            if (ar_tgt == TGT_W'(n)) begin
                o_arvalid[n] = i_arvalid;
                i_arready    = o_arready[n];
            end
        end
        err_ar_hs = i_arvalid && i_arready && ar_tgt == ERR;
    end

    always_comb begin
        b_req    = {err_bvalid, o_bvalid};
        b_gnt    = b_lock_q ? b_gnt_q : rr_pick(b_req, b_ptr_q);
        i_bvalid = b_req[b_gnt];
        i_bch    = {2'b11, werr_id_q};
        o_bready = '0;
        for (int n = 0; n < int'(SLV_NB); n++) begin
            if (b_gnt == TGT_W'(n)) begin
                i_bch       = o_bch[n*BCH_W +: BCH_W];
                o_bready[n] = i_bready && o_bvalid[n];
            end
        end
        b_hs = i_bvalid && i_bready;

        r_req    = {err_rvalid, o_rvalid};
        r_gnt    = r_lock_q ? r_gnt_q : rr_pick(r_req, r_ptr_q);
        i_rvalid = r_req[r_gnt];
        i_rch    = {2'b11, rerr_id_q, {AXI_DATA_W{1'b0}}};
        i_rlast  = rerr_cnt_q == 8'd0;
        o_rready = '0;
        for (int n = 0; n < int'(SLV_NB); n++) begin
            if (r_gnt == TGT_W'(n)) begin
                i_rch       = o_rch[n*RCH_W +: RCH_W];
                i_rlast     = o_rlast[n];
                o_rready[n] = i_rready && o_rvalid[n];
            end
        end
        r_hs     = i_rvalid && i_rready;
        r_done   = r_hs && i_rlast;
        err_r_hs = r_hs && r_gnt == ERR;
    end

    always_ff @(posedge aclk) begin
        if (push) fifo_q[wr_ptr_q] <= aw_tgt;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
            b_ptr_q  <= '0; b_gnt_q  <= '0; b_lock_q <= 1'b0;
            r_ptr_q  <= '0; r_gnt_q  <= '0; r_lock_q <= 1'b0;
        end else if (srst) begin
            wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
            b_ptr_q  <= '0; b_gnt_q  <= '0; b_lock_q <= 1'b0;
            r_ptr_q  <= '0; r_gnt_q  <= '0; r_lock_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + (PTR_W + 1)'(1);
            else if (pop && !push) cnt_q <= cnt_q - (PTR_W + 1)'(1);
            if (b_hs) b_ptr_q <= rr_next(b_gnt);
            b_gnt_q  <= b_gnt;
            b_lock_q <= i_bvalid && !i_bready;
            if (r_done) r_ptr_q <= rr_next(r_gnt);
            r_gnt_q  <= r_gnt;
            // Hold the R grant across gaps between beats until the last beat is taken.
            r_lock_q <= (r_lock_q || i_rvalid) && !r_done;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            werr_q <= WIdle;
            rerr_q <= RIdle;
        end else if (srst) begin
            werr_q <= WIdle;
            rerr_q <= RIdle;
        end else begin
            werr_q <= werr_d;
            rerr_q <= rerr_d;
        end
    end

    always_comb begin
        werr_d = werr_q;
        unique case (werr_q)
            WIdle:   if (err_push) werr_d = WData;
            WData:   if (err_pop)  werr_d = WResp;
            WResp:   if (b_hs && b_gnt == ERR) werr_d = WIdle;
            default: werr_d = WIdle;
        endcase
        rerr_d = rerr_q;
        unique case (rerr_q)
            RIdle:   if (err_ar_hs) rerr_d = RBurst;
            RBurst:  if (err_r_hs && rerr_cnt_q == 8'd0) rerr_d = RIdle;
            default: rerr_d = RIdle;
        endcase
    end

    always_comb begin
        werr_idle  = werr_q == WIdle;
        err_bvalid = werr_q == WResp;
        rerr_idle  = rerr_q == RIdle;
        err_rvalid = rerr_q == RBurst;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            werr_id_q <= '0; rerr_id_q <= '0; rerr_cnt_q <= '0;
        end else if (srst) begin
            werr_id_q <= '0; rerr_id_q <= '0; rerr_cnt_q <= '0;
        end else begin
            if (err_push) werr_id_q <= i_awch[AXI_ADDR_W +: AXI_ID_W];
            if (err_ar_hs) begin
                rerr_id_q  <= i_arch[AXI_ADDR_W +: AXI_ID_W];
                rerr_cnt_q <= i_arch[AXI_ADDR_W + AXI_ID_W +: 8];
            end else if (err_r_hs) begin
                rerr_cnt_q <= rerr_cnt_q - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axicb_mst_switch.sv
// Directed bench for axicb_mst_switch: decode, W steering, DECERR paths, B/R arbitration, reset.
module tb_axicb_mst_switch;

    localparam int SLV_NB = 4;
    localparam int AWCH_W = 32;
    localparam int WCH_W  = 8;
    localparam int ARCH_W = 40;
    localparam int BCH_W  = 10;
    localparam int RCH_W  = 18;

    logic aclk = 1'b0;
    logic areset, srst;
    logic i_awvalid, i_awready, i_wvalid, i_wready, i_wlast, i_bvalid, i_bready;
    logic i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
    logic [AWCH_W-1:0] i_awch;
    logic [WCH_W-1:0]  i_wch;
    logic [BCH_W-1:0]  i_bch;
    logic [ARCH_W-1:0] i_arch;
    logic [RCH_W-1:0]  i_rch;
    logic [SLV_NB-1:0] o_awvalid, o_awready, o_wvalid, o_wready, o_wlast, o_bvalid, o_bready;
    logic [SLV_NB-1:0] o_arvalid, o_arready, o_rvalid, o_rready, o_rlast;
    logic [SLV_NB*AWCH_W-1:0] o_awch;
    logic [SLV_NB*WCH_W-1:0]  o_wch;
    logic [SLV_NB*BCH_W-1:0]  o_bch;
    logic [SLV_NB*ARCH_W-1:0] o_arch;
    logic [SLV_NB*RCH_W-1:0]  o_rch;

    int n_checks = 0;
    int n_fail   = 0;

    axicb_mst_switch dut (
        .aclk(aclk), .areset(areset), .srst(srst),
        .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
        .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
        .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
        .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
        .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
        .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
        .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_aw(input logic [15:0] addr, input logic [7:0] id);
        i_awvalid = 1'b1;
        i_awch    = {8'h00, id, addr};
    endtask

    int            exp_slv [4] = '{0, 2, 3, 1};
    int            rbeat;
    int            rcnt [SLV_NB];
    int            es, eb;
    logic [3:0]    onehot;
    logic          rpat [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [RCH_W-1:0] exp_r;

    initial begin
        areset = 1'b1; srst = 1'b0;
        i_awvalid = 0; i_awch = '0; i_wvalid = 0; i_wlast = 0; i_wch = '0; i_bready = 0;
        i_arvalid = 0; i_arch = '0; i_rready = 0;
        o_awready = '1; o_wready = '1; o_bvalid = '0; o_bch = '0; o_arready = '1;
        o_rvalid = '0; o_rlast = '0; o_rch = '0;
        tick();
        tick();
        check_eq("rst_wready", i_wready, 1'b0);
        check_eq("rst_bvalid", i_bvalid, 1'b0);
        check_eq("rst_rvalid", i_rvalid, 1'b0);
        check_eq("rst_o_wvalid", o_wvalid, 4'b0000);
        areset = 1'b0;
        tick();

        // Address decode boundaries on the read side
        i_arvalid = 1'b1;
        i_arch = {8'h00, 8'h01, 16'h0FFF};
        #1 check_eq("dec_0fff", o_arvalid, 4'b0001);
        i_arch = {8'h00, 8'h01, 16'h3FFF};
        #1 check_eq("dec_3fff", o_arvalid, 4'b1000);
        i_arch = {8'h00, 8'h01, 16'h4000};
        #1 check_eq("dec_4000", o_arvalid, 4'b0000);
        check_eq("dec_4000_rdy", i_arready, 1'b1);
        i_arvalid = 1'b0;

        // 1: write to slave 1 and its B response
        drive_aw(16'h1004, 8'h05);
        #1 check_eq("t1_awvalid", o_awvalid, 4'b0010);
        check_eq("t1_awready", i_awready, 1'b1);
        tick();
        i_awvalid = 1'b0;
        i_wvalid = 1'b1; i_wlast = 1'b1; i_wch = 8'hA5;
        #1 check_eq("t1_wvalid", o_wvalid, 4'b0010);
        check_eq("t1_wready", i_wready, 1'b1);
        check_eq("t1_wch", o_wch[15:8], 8'hA5);
        tick();
        i_wvalid = 1'b0;
        #1 check_eq("t1_wready_empty", i_wready, 1'b0);
        o_bvalid = 4'b0010; o_bch[19:10] = 10'h005; i_bready = 1'b1;
        #1 check_eq("t1_bvalid", i_bvalid, 1'b1);
        check_eq("t1_bch", i_bch, 10'h005);
        check_eq("t1_bready", o_bready, 4'b0010);
        tick();
        o_bvalid = '0;

        // 2: fill the W-route FIFO, then drain in AW order
        for (int k = 0; k < 4; k++) begin
            drive_aw(16'(exp_slv[k] * 'h1000), 8'(8'h20 + k));
            #1 check_eq($sformatf("t2_aw%0d_rdy", k), i_awready, 1'b1);
            tick();
        end
        drive_aw(16'h0000, 8'h24);
        #1 check_eq("t2_full_awready", i_awready, 1'b0);
        check_eq("t2_full_awvalid", o_awvalid, 4'b0000);
        i_awvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 2; b++) begin
                i_wvalid = 1'b1; i_wlast = (b == 1);
                onehot = 4'b0001 << exp_slv[k];
                #1 check_eq($sformatf("t2_w%0d_b%0d", k, b), o_wvalid, onehot);
                tick();
            end
        end
        i_wvalid = 1'b0;
        #1 check_eq("t2_drained", i_wready, 1'b0);

        // 3: unmapped write completes with DECERR
        drive_aw(16'h8000, 8'h07);
        #1 check_eq("t3_awready", i_awready, 1'b1);
        check_eq("t3_awvalid", o_awvalid, 4'b0000);
        tick();
        drive_aw(16'h9000, 8'h08);
        #1 check_eq("t3_err_stall", i_awready, 1'b0);
        i_awvalid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            i_wvalid = 1'b1; i_wlast = (b == 2);
            #1 check_eq($sformatf("t3_wready%0d", b), i_wready, 1'b1);
            check_eq($sformatf("t3_wvalid%0d", b), o_wvalid, 4'b0000);
            tick();
        end
        i_wvalid = 1'b0;
        #1 check_eq("t3_bvalid", i_bvalid, 1'b1);
        check_eq("t3_bch", i_bch, 10'h307);
        check_eq("t3_bready", o_bready, 4'b0000);
        tick();
        check_eq("t3_b_once", i_bvalid, 1'b0);

        // 4: unmapped read, LEN 3, with i_rready toggling
        i_arvalid = 1'b1; i_arch = {8'd3, 8'h03, 16'h9000};
        #1 check_eq("t4_arready", i_arready, 1'b1);
        check_eq("t4_arvalid", o_arvalid, 4'b0000);
        tick();
        i_arvalid = 1'b0;
        rbeat = 0;
        for (int c = 0; c < 7; c++) begin
            i_rready = rpat[c];
            #1 check_eq($sformatf("t4_rvalid_c%0d", c), i_rvalid, 1'b1);
            check_eq($sformatf("t4_rch_c%0d", c), i_rch, 18'h30300);
            check_eq($sformatf("t4_rlast_c%0d", c), i_rlast, rbeat == 3);
            if (rpat[c]) rbeat++;
            tick();
        end
        i_rready = 1'b0;
        #1 check_eq("t4_done", i_rvalid, 1'b0);

        // 5: slaves 0 and 2 contend; bursts must not interleave
        rcnt = '{default: 0};
        i_rready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            o_rvalid = '0; o_rlast = '0;
            for (int s = 0; s < SLV_NB; s += 2) begin
                o_rvalid[s] = rcnt[s] < 4;
                o_rlast[s]  = rcnt[s] == 3;
                o_rch[s*RCH_W +: RCH_W] = {2'b00, 8'(8'h10 + s), 8'(rcnt[s])};
            end
            es = (j < 4) ? 0 : 2;
            eb = j % 4;
            exp_r = {2'b00, 8'(8'h10 + es), 8'(eb)};
            onehot = 4'b0001 << es;
            #1 check_eq($sformatf("t5_rch%0d", j), i_rch, exp_r);
            check_eq($sformatf("t5_rready%0d", j), o_rready, onehot);
            check_eq($sformatf("t5_rlast%0d", j), i_rlast, eb == 3);
            tick();
            rcnt[es]++;
        end
        o_rvalid = '0; o_rlast = '0; i_rready = 1'b0;
        #1 check_eq("t5_idle", i_rvalid, 1'b0);

        // 6: asynchronous reset in the middle of a write burst
        drive_aw(16'h2000, 8'h0A);
        tick();
        i_awvalid = 1'b0;
        i_wvalid = 1'b1; i_wlast = 1'b0;
        #1 check_eq("t6_wvalid", o_wvalid, 4'b0100);
        tick();
        areset = 1'b1;
        #1 check_eq("t6_rst_wready", i_wready, 1'b0);
        check_eq("t6_rst_bvalid", i_bvalid, 1'b0);
        check_eq("t6_rst_o_wvalid", o_wvalid, 4'b0000);
        tick();
        areset = 1'b0;
        #1 check_eq("t6_post_wready", i_wready, 1'b0);
        i_wvalid = 1'b0;
        drive_aw(16'h3000, 8'h09);
        #1 check_eq("t6_awvalid", o_awvalid, 4'b1000);
        tick();
        i_awvalid = 1'b0;
        i_wvalid = 1'b1; i_wlast = 1'b1;
        #1 check_eq("t6_wvalid2", o_wvalid, 4'b1000);
        tick();
        i_wvalid = 1'b0;
        o_bvalid = 4'b1000; o_bch[39:30] = 10'h009; i_bready = 1'b1;
        #1 check_eq("t6_bch", i_bch, 10'h009);
        check_eq("t6_bready", o_bready, 4'b1000);
        tick();
        o_bvalid = '0;

        // Synchronous clear empties the FIFO like areset
        drive_aw(16'h0000, 8'h0B);
        tick();
        i_awvalid = 1'b0;
        srst = 1'b1;
        tick();
        srst = 1'b0;
        i_wvalid = 1'b1; i_wlast = 1'b1;
        #1 check_eq("srst_wready", i_wready, 1'b0);
        i_wvalid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
